// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the five-stage MIPS core. Tracks the
//   in-flight writers in E, M and W from the decode descriptor, ages their
//   cycles-until-result every clock, and derives the D-stage stall plus all
//   forwarding-mux selects for the D, E and M operands.
//
// Ports
//   clk                  core clock, rising edge
//   rst_n                synchronous active-low reset
//   d_r_new / d_t_new    D destination register (0 = none) / cycles until result
//   d_r_use1, d_r_use2   D source registers (0 = none)
//   d_t_use1, d_t_use2   cycles from D until each source is needed
//   stall                hold PC and D register, inject bubble into E
//   fwd_d1, fwd_d2       D operand select: 0 regfile, 1 E result, 2 M result
//   fwd_e1, fwd_e2       E operand select: 0 pipeline, 1 M result, 2 W result
//   fwd_m2               M store-data select: 0 pipeline, 1 W result
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d_r_new,
    input  logic [1:0] d_t_new,
    input  logic [4:0] d_r_use1,
    input  logic [4:0] d_r_use2,
    input  logic [1:0] d_t_use1,
    input  logic [1:0] d_t_use2,
    output logic       stall,
    output logic [1:0] fwd_d1,
    output logic [1:0] fwd_d2,
    output logic [1:0] fwd_e1,
    output logic [1:0] fwd_e2,
    output logic       fwd_m2
);

    // Writer and reader records. W keeps only its register: W never stalls
    // and always has its result, so its timing carries no information.
    logic [4:0] e_r_new, e_r_use1, e_r_use2;
    logic [1:0] e_t_new;
    logic [4:0] m_r_new, m_r_use2;
    logic [1:0] m_t_new;
    logic [4:0] w_r_new;

    // One cycle closer to the result, saturating at zero.
    function automatic logic [1:0] age(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Register 0 is hard-wired, so it never matches anything.
    function automatic logic match(input logic [4:0] r_new, input logic [4:0] r);
        return (r != 5'd0) && (r_new == r);
    endfunction

    function automatic logic need_stall(input logic [4:0] r, input logic [1:0] t_use,
                                        input logic [4:0] er, input logic [1:0] et,
                                        input logic [4:0] mr, input logic [1:0] mt);
        return (match(er, r) && (et > t_use)) || (match(mr, r) && (mt > t_use));
    endfunction

    // Nearest stage with a finished result wins.
    function automatic logic [1:0] sel_d(input logic [4:0] r);
        if (match(e_r_new, r) && (e_t_new == 2'd0))
            return 2'd1;
        else if (match(m_r_new, r) && (m_t_new == 2'd0))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r);
        if (match(m_r_new, r) && (m_t_new == 2'd0))
            return 2'd1;
        else if (match(w_r_new, r))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        stall  = need_stall(d_r_use1, d_t_use1, e_r_new, e_t_new, m_r_new, m_t_new)
              || need_stall(d_r_use2, d_t_use2, e_r_new, e_t_new, m_r_new, m_t_new);
        fwd_d1 = sel_d(d_r_use1);
        fwd_d2 = sel_d(d_r_use2);
        fwd_e1 = sel_e(e_r_use1);
        fwd_e2 = sel_e(e_r_use2);
        fwd_m2 = match(w_r_new, m_r_use2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_r_new  <= 5'd0;
            e_t_new  <= 2'd0;
            e_r_use1 <= 5'd0;
            e_r_use2 <= 5'd0;
            m_r_new  <= 5'd0;
            m_t_new  <= 2'd0;
            m_r_use2 <= 5'd0;
            w_r_new  <= 5'd0;
        end else begin
            // A stalled D instruction stays in D; E receives a bubble.
            if (stall) begin
                e_r_new  <= 5'd0;
                e_t_new  <= 2'd0;
                e_r_use1 <= 5'd0;
                e_r_use2 <= 5'd0;
            end else begin
                e_r_new  <= d_r_new;
                e_t_new  <= age(d_t_new);
                e_r_use1 <= d_r_use1;
                e_r_use2 <= d_r_use2;
            end
            // E, M and W always advance, so a stall drains on its own.
            m_r_new  <= e_r_new;
            m_t_new  <= age(e_t_new);
            m_r_use2 <= e_r_use2;
            w_r_new  <= m_r_new;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core: consumes the per-instruction register/timing descriptor produced at decode (write register and cycles-until-result, plus up to two read registers and cycles-until-needed). It keeps a registered scoreboard of in-flight writers in E, M and W and ages their timing each cycle. From that it decides the D-stage stall and drives all forwarding-mux selects for D, E and M operands. It sits beside the datapath; the decode descriptor is its only instruction-level input.

## Interface
- No parameters; register fields 5 bits, timing fields 2 bits, fixed.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- d_r_new  in  5  D-stage destination register (0 = none)
- d_t_new  in  2  D-stage cycles from D until result exists (0..3)
- d_r_use1, d_r_use2  in  5 each  D-stage source registers (0 = none)
- d_t_use1, d_t_use2  in  2 each  D-stage cycles from D until each source is needed
- stall  out  1  hold PC and D register, inject bubble into E
- fwd_d1, fwd_d2  out  2 each  D operand select: 0 regfile, 1 E result, 2 M result
- fwd_e1, fwd_e2  out  2 each  E operand select: 0 pipeline value, 1 M result, 2 W result
- fwd_m2  out  1  M store-data select: 0 pipeline value, 1 W result

## Operation
- Scoreboard: three writer records E, M, W, each {r_new[4:0], t_new[1:0]}. Use records: E holds {r_use1, r_use2}; M holds {r_use2}.
- Aging: age(t) = (t == 0) ? 0 : t - 1, 2-bit saturating.
- Capture into E record when stall = 0: r_new = d_r_new, t_new = age(d_t_new), r_use1/2 = d_r_use1/2. When stall = 1: E record becomes bubble (all fields 0).
- Every cycle, stall or not: M writer <= {E.r_new, age(E.t_new)}, W writer <= {M.r_new, age(M.t_new)}, M.r_use2 <= E.r_use2.
- Match(stage, r) = (r != 0) && (stage.r_new == r). Register 0 never matches, never stalls, never forwards.
- Stall, combinational: for i in {1,2}, stall if Match(E, d_r_use_i) && E.t_new > d_t_use_i, or if Match(M, d_r_use_i) && M.t_new > d_t_use_i. W never stalls.
- Forwarding always picks the nearest stage first.
- fwd_d_i: 1 if Match(E, d_r_use_i) && E.t_new == 0. Else 2 if Match(M, d_r_use_i) && M.t_new == 0. Else 0.
- W-to-D bypass belongs to the regfile, not this block.
- fwd_e_i: 1 if Match(M, E.r_use_i) && M.t_new == 0. Else 2 if Match(W, E.r_use_i). Else 0.
- fwd_m2: 1 if Match(W, M.r_use2). Else 0.
- Forward selects are valid in the same cycle as stall. A stalled D operand's select is don't-care.

## Timing
- Reset (rst_n low at clk edge): all records cleared to 0. Outputs are then stall = 0 and all fwd_* = 0 from the following cycle until new records arrive.
- Reset has priority over stall and capture. Reset asserted mid-stall clears the stall on the next cycle.
- stall and fwd_* are purely combinational from current records plus d_* inputs; zero-cycle latency.
- Resulting stall lengths (e.g. t_new lw = 3, ALU = 2, jal = 2; t_use beq/jr = 0, ALU = 1, sw rt = 2):
  - lw followed immediately by ALU user: 1 stall.
  - lw followed immediately by beq: 2 stalls.
  - ALU followed immediately by beq: 1 stall.
- Back-to-back stalls: D inputs are held by the datapath. Records keep draining, so stall deasserts automatically once t_new ≤ t_use.
- Simultaneous match in E and M with different t_new: stall if either stage violates. Forward selection still prefers E.

## Test plan
- Reset: hold rst_n = 0 two cycles with random d_* inputs -> after release, stall = 0 and all fwd_* = 0 before any new capture.
- ALU chain: D {r_new=8, t_new=2}, then D {r_use1=8, t_use1=1} -> no stall. Next cycle fwd_e1 = 1; had it been one instruction later, fwd_e1 = 2.
- Load-use: D {r_new=9, t_new=3}, then D {r_use2=9, t_use2=1} -> stall = 1 for exactly 1 cycle, E bubble captured, then fwd_e2 = 2.
- Load-branch: D {r_new=10, t_new=3}, then D {r_use1=10, t_use1=0} -> stall high 2 cycles, then fwd_d1 = 0 (regfile bypass).
- jal then jr $31: D {r_new=31, t_new=2}, then D {r_use1=31, t_use1=0} -> stall 1 cycle, then fwd_d1 = 2. Store-data: lw r5 then sw using r5 as rt (t_use2=2) -> no stall; in M, fwd_m2 = 1.
- Register 0 and priority: writer r_new=0 with a reader r_use1=0 -> never stall or forward. Two writers to r4 (t_new=2), then a reader of r4 -> fwd_e1 = 1 (M), not 2; also reset asserted during a load-branch stall -> stall = 0 next cycle.
